hazard_control_unit: RTL and testbench

- Pipeline hazard controller for the 5-stage RISC-V core; complements the forwarding path by covering the hazards bypassing cannot resolve.
- Generates stall (write-enable) and flush/bubble controls for the IF/ID, ID/EX, EX/MEM and MEM/WB registers and the PC, covering:
  - load-use hazards;
  - taken branch/jump redirects;
  - data-memory wait states, with a timeout fault.
- Keeps saturating stall/flush performance counters.

---
 rtl/core_ctrl_pkg.sv | 13 +
 rtl/hazard_control_unit_if.sv | 43 ++++
 rtl/sat_counter.sv | 25 ++
 rtl/hazard_control_unit.sv | 126 ++++++++++++
 tb/tb_hazard_control_unit.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/core_ctrl_pkg.sv
// Shared control types and constants for the core pipeline controllers.
package core_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FAULT    = 2'd2
  } hz_state_e;

  localparam logic [4:0] REG_ZERO            = 5'd0;
  localparam int         MEM_TIMEOUT_DEFAULT = 16;

endpackage

// File: rtl/hazard_control_unit_if.sv
// Hazard controller bundle: pipeline status in, stage enables/flushes and status out.
interface hazard_control_unit_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       if_id_rs1;
  logic [4:0]       if_id_rs2;
  logic             if_id_uses_rs1;
  logic             if_id_uses_rs2;
  logic [4:0]       id_ex_rd;
  logic             id_ex_memread;
  logic             ex_branch_taken;
  logic             dmem_req;
  logic             dmem_ready;

  logic             pc_write;
  logic             if_id_write;
  logic             id_ex_write;
  logic             ex_mem_write;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             mem_wb_bubble;
  logic             mem_fault;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_events;
  logic [1:0]       state;

  modport master (
    output if_id_rs1, if_id_rs2, if_id_uses_rs1, if_id_uses_rs2,
           id_ex_rd, id_ex_memread, ex_branch_taken, dmem_req, dmem_ready,
    input  pc_write, if_id_write, id_ex_write, ex_mem_write,
           if_id_flush, id_ex_flush, mem_wb_bubble, mem_fault,
           stall_cycles, flush_events, state
  );

  modport slave (
    input  if_id_rs1, if_id_rs2, if_id_uses_rs1, if_id_uses_rs2,
           id_ex_rd, id_ex_memread, ex_branch_taken, dmem_req, dmem_ready,
    output pc_write, if_id_write, id_ex_write, ex_mem_write,
           if_id_flush, id_ex_flush, mem_wb_bubble, mem_fault,
           stall_cycles, flush_events, state
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with enable and synchronous active-low clear.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (en && (count_q != '1)) count_d = count_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_control_unit.sv
// Load-use, redirect and data-memory-wait hazard control for the 5-stage pipeline,
// with a timeout fault state and saturating stall/flush counters.
module hazard_control_unit
  import core_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT,
  parameter int CNT_W       = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  hazard_control_unit_if.slave  hz
);

  localparam int                WAIT_W    = $clog2(MEM_TIMEOUT) + 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  hz_state_e         state_d, state_q;
  logic [WAIT_W-1:0] wait_cnt_d, wait_cnt_q;
  logic              mem_fault_d, mem_fault_q;

  logic memstall, loaduse, rs1_hit, rs2_hit;
  logic pc_wr, ifid_wr, idex_wr, exmem_wr, ifid_fl, idex_fl, memwb_bub;
  logic stall_inc, flush_inc;

  assign memstall = hz.dmem_req & ~hz.dmem_ready;
  assign rs1_hit  = hz.if_id_uses_rs1 && (hz.if_id_rs1 == hz.id_ex_rd);
  assign rs2_hit  = hz.if_id_uses_rs2 && (hz.if_id_rs2 == hz.id_ex_rd);
  assign loaduse  = hz.id_ex_memread && (hz.id_ex_rd != REG_ZERO) && (rs1_hit || rs2_hit);

  // Stage controls. Reset and FAULT both leave everything deasserted.
  // NOTE: every output gets a default first so no path can infer a latch.
  always_comb begin
    pc_wr     = 1'b0;
    ifid_wr   = 1'b0;
    idex_wr   = 1'b0;
    exmem_wr  = 1'b0;
    ifid_fl   = 1'b0;
    idex_fl   = 1'b0;
    memwb_bub = 1'b0;
    if (rst_n && (state_q != FAULT)) begin
      if (memstall) begin
        memwb_bub = 1'b1;
      end else if (hz.ex_branch_taken) begin
        {pc_wr, ifid_wr, idex_wr, exmem_wr} = 4'b1111;
        ifid_fl = 1'b1;
        idex_fl = 1'b1;
      end else if (loaduse) begin
        // Hold PC and IF/ID, insert one bubble; the load advances into MEM.
        idex_wr  = 1'b1;
        exmem_wr = 1'b1;
        idex_fl  = 1'b1;
      end else begin
        {pc_wr, ifid_wr, idex_wr, exmem_wr} = 4'b1111;
      end
    end
  end

  assign stall_inc = rst_n && (state_q != FAULT) && !pc_wr;
  assign flush_inc = ifid_fl;

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    mem_fault_d = mem_fault_q;
    unique case (state_q)
      RUN: begin
        if (memstall) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = WAIT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (!memstall) begin
          // Either the access completed or the request was withdrawn.
          state_d    = RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d     = FAULT;
          mem_fault_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      FAULT:   state_d = FAULT;
      default: state_d = RUN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= RUN;
      wait_cnt_q  <= '0;
      mem_fault_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_fault_q <= mem_fault_d;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (stall_inc),
    .count (hz.stall_cycles)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (flush_inc),
    .count (hz.flush_events)
  );

  assign hz.pc_write      = pc_wr;
  assign hz.if_id_write   = ifid_wr;
  assign hz.id_ex_write   = idex_wr;
  assign hz.ex_mem_write  = exmem_wr;
  assign hz.if_id_flush   = ifid_fl;
  assign hz.id_ex_flush   = idex_fl;
  assign hz.mem_wb_bubble = memwb_bub;
  assign hz.mem_fault     = mem_fault_q;
  assign hz.state         = state_q;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench: two instances (default config, and MEM_TIMEOUT=4/CNT_W=4) share stimulus.
module tb_hazard_control_unit;

  // {pc_write, if_id_write, id_ex_write, ex_mem_write, if_id_flush, id_ex_flush, mem_wb_bubble}
  localparam logic [6:0] C_RUN    = 7'b1111_000;
  localparam logic [6:0] C_BRANCH = 7'b1111_110;
  localparam logic [6:0] C_LU     = 7'b0011_010;
  localparam logic [6:0] C_FREEZE = 7'b0000_001;
  localparam logic [6:0] C_OFF    = 7'b0000_000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] rs1, rs2, rd;
  logic       u1, u2, memread, br, dreq, drdy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_control_unit_if #(.CNT_W(32)) a_if ();
  hazard_control_unit_if #(.CNT_W(4))  b_if ();

  assign a_if.if_id_rs1 = rs1;      assign b_if.if_id_rs1 = rs1;
  assign a_if.if_id_rs2 = rs2;      assign b_if.if_id_rs2 = rs2;
  assign a_if.if_id_uses_rs1 = u1;  assign b_if.if_id_uses_rs1 = u1;
  assign a_if.if_id_uses_rs2 = u2;  assign b_if.if_id_uses_rs2 = u2;
  assign a_if.id_ex_rd = rd;        assign b_if.id_ex_rd = rd;
  assign a_if.id_ex_memread = memread; assign b_if.id_ex_memread = memread;
  assign a_if.ex_branch_taken = br; assign b_if.ex_branch_taken = br;
  assign a_if.dmem_req = dreq;      assign b_if.dmem_req = dreq;
  assign a_if.dmem_ready = drdy;    assign b_if.dmem_ready = drdy;

  hazard_control_unit #(.MEM_TIMEOUT(16), .CNT_W(32)) u_dut_a (
    .clk (clk), .rst_n (rst_n), .hz (a_if.slave)
  );

  hazard_control_unit #(.MEM_TIMEOUT(4), .CNT_W(4)) u_dut_b (
    .clk (clk), .rst_n (rst_n), .hz (b_if.slave)
  );

  function automatic logic [6:0] ctl_a();
    return {a_if.pc_write, a_if.if_id_write, a_if.id_ex_write, a_if.ex_mem_write,
            a_if.if_id_flush, a_if.id_ex_flush, a_if.mem_wb_bubble};
  endfunction

  function automatic logic [6:0] ctl_b();
    return {b_if.pc_write, b_if.if_id_write, b_if.id_ex_write, b_if.ex_mem_write,
            b_if.if_id_flush, b_if.id_ex_flush, b_if.mem_wb_bubble};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0; u1 = 1'b0; u2 = 1'b0;
    memread = 1'b0; br = 1'b0; dreq = 1'b0; drdy = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle();
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic set_loaduse(input logic [4:0] dst);
    memread = 1'b1; rd = dst; rs1 = 5'd3; u1 = 1'b1; rs2 = 5'd5; u2 = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    dreq = 1'b1; br = 1'b1; set_loaduse(5'd5);
    tick();
    #1;
    checks++; if (ctl_a() !== C_OFF) begin errors++; $display("FAIL rst_ctl got %b exp %b", ctl_a(), C_OFF); end
    checks++; if (a_if.state !== 2'd0) begin errors++; $display("FAIL rst_state got %0d exp 0", a_if.state); end
    checks++; if (a_if.mem_fault !== 1'b0) begin errors++; $display("FAIL rst_fault got %b exp 0", a_if.mem_fault); end
    checks++; if (a_if.stall_cycles !== 32'd0 || a_if.flush_events !== 32'd0) begin
      errors++; $display("FAIL rst_cnt got %0d/%0d exp 0/0", a_if.stall_cycles, a_if.flush_events); end
    rst_n = 1'b1;
    idle();
    #1;
    checks++; if (ctl_a() !== C_RUN) begin errors++; $display("FAIL rst_run_ctl got %b exp %b", ctl_a(), C_RUN); end
  endtask

  task automatic test_load_use();
    do_reset();
    set_loaduse(5'd5);
    u1 = 1'b0;
    #1;
    checks++; if (ctl_a() !== C_LU) begin errors++; $display("FAIL lu_rs2_ctl got %b exp %b", ctl_a(), C_LU); end
    tick();
    checks++; if (a_if.stall_cycles !== 32'd1) begin errors++; $display("FAIL lu_stall got %0d exp 1", a_if.stall_cycles); end
    memread = 1'b0; rd = 5'd9;
    #1;
    checks++; if (ctl_a() !== C_RUN) begin errors++; $display("FAIL lu_one_bubble got %b exp %b", ctl_a(), C_RUN); end
    memread = 1'b1; rd = 5'd0; rs1 = 5'd0; u1 = 1'b1; rs2 = 5'd0; u2 = 1'b1;
    #1;
    checks++; if (ctl_a() !== C_RUN) begin errors++; $display("FAIL lu_x0 got %b exp %b", ctl_a(), C_RUN); end
    rd = 5'd7; rs1 = 5'd7; u1 = 1'b1; rs2 = 5'd1;
    #1;
    checks++; if (ctl_a() !== C_LU) begin errors++; $display("FAIL lu_rs1_ctl got %b exp %b", ctl_a(), C_LU); end
    u1 = 1'b0;
    #1;
    checks++; if (ctl_a() !== C_RUN) begin errors++; $display("FAIL lu_unused got %b exp %b", ctl_a(), C_RUN); end
    memread = 1'b0; u1 = 1'b1;
    #1;
    checks++; if (ctl_a() !== C_RUN) begin errors++; $display("FAIL lu_noload got %b exp %b", ctl_a(), C_RUN); end
    tick();
    checks++; if (a_if.stall_cycles !== 32'd1) begin errors++; $display("FAIL lu_stall_hold got %0d exp 1", a_if.stall_cycles); end
    idle();
  endtask

  task automatic test_branch_over_loaduse();
    do_reset();
    set_loaduse(5'd5);
    br = 1'b1;
    #1;
    checks++; if (ctl_a() !== C_BRANCH) begin errors++; $display("FAIL br_lu_ctl got %b exp %b", ctl_a(), C_BRANCH); end
    tick();
    idle();
    checks++; if (a_if.flush_events !== 32'd1) begin errors++; $display("FAIL br_lu_flush got %0d exp 1", a_if.flush_events); end
    checks++; if (a_if.stall_cycles !== 32'd0) begin errors++; $display("FAIL br_lu_stall got %0d exp 0", a_if.stall_cycles); end
  endtask

  task automatic test_mem_wait();
    logic [1:0] exp_state;
    do_reset();
    dreq = 1'b1; drdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp_state = (i == 0) ? 2'd0 : 2'd1;
      #1;
      checks++; if (ctl_a() !== C_FREEZE) begin errors++; $display("FAIL mw_ctl[%0d] got %b exp %b", i, ctl_a(), C_FREEZE); end
      checks++; if (a_if.state !== exp_state) begin errors++; $display("FAIL mw_state[%0d] got %0d exp %0d", i, a_if.state, exp_state); end
      tick();
    end
    checks++; if (a_if.state !== 2'd1) begin errors++; $display("FAIL mw_state3 got %0d exp 1", a_if.state); end
    checks++; if (a_if.stall_cycles !== 32'd3) begin errors++; $display("FAIL mw_stall got %0d exp 3", a_if.stall_cycles); end
    drdy = 1'b1;
    #1;
    checks++; if (ctl_a() !== C_RUN) begin errors++; $display("FAIL mw_done_ctl got %b exp %b", ctl_a(), C_RUN); end
    tick();
    idle();
    checks++; if (a_if.state !== 2'd0) begin errors++; $display("FAIL mw_back_run got %0d exp 0", a_if.state); end
    checks++; if (a_if.stall_cycles !== 32'd3) begin errors++; $display("FAIL mw_stall_hold got %0d exp 3", a_if.stall_cycles); end
  endtask

  task automatic test_branch_during_wait();
    do_reset();
    dreq = 1'b1; drdy = 1'b0; br = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (ctl_a() !== C_FREEZE) begin errors++; $display("FAIL bw_frozen[%0d] got %b exp %b", i, ctl_a(), C_FREEZE); end
      tick();
    end
    checks++; if (a_if.flush_events !== 32'd0) begin errors++; $display("FAIL bw_noflush got %0d exp 0", a_if.flush_events); end
    drdy = 1'b1;
    #1;
    checks++; if (ctl_a() !== C_BRANCH) begin errors++; $display("FAIL bw_release got %b exp %b", ctl_a(), C_BRANCH); end
    tick();
    idle();
    checks++; if (a_if.flush_events !== 32'd1) begin errors++; $display("FAIL bw_flush got %0d exp 1", a_if.flush_events); end
    checks++; if (a_if.state !== 2'd0) begin errors++; $display("FAIL bw_state got %0d exp 0", a_if.state); end
  endtask

  task automatic test_spurious_wait();
    do_reset();
    dreq = 1'b1; drdy = 1'b0;
    tick();
    checks++; if (a_if.state !== 2'd1) begin errors++; $display("FAIL sp_wait got %0d exp 1", a_if.state); end
    dreq = 1'b0;
    #1;
    checks++; if (ctl_a() !== C_RUN) begin errors++; $display("FAIL sp_ctl got %b exp %b", ctl_a(), C_RUN); end
    tick();
    checks++; if (a_if.state !== 2'd0) begin errors++; $display("FAIL sp_state got %0d exp 0", a_if.state); end
    idle();
  endtask

  task automatic test_timeout();
    do_reset();
    dreq = 1'b1; drdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (ctl_b() !== C_FREEZE) begin errors++; $display("FAIL to_frozen[%0d] got %b exp %b", i, ctl_b(), C_FREEZE); end
      checks++; if (b_if.mem_fault !== 1'b0) begin errors++; $display("FAIL to_early_fault[%0d] got %b exp 0", i, b_if.mem_fault); end
      tick();
    end
    checks++; if (b_if.state !== 2'd2) begin errors++; $display("FAIL to_state got %0d exp 2", b_if.state); end
    checks++; if (b_if.mem_fault !== 1'b1) begin errors++; $display("FAIL to_fault got %b exp 1", b_if.mem_fault); end
    checks++; if (ctl_b() !== C_OFF) begin errors++; $display("FAIL to_ctl got %b exp %b", ctl_b(), C_OFF); end
    checks++; if (b_if.stall_cycles !== 4'd4) begin errors++; $display("FAIL to_stall got %0d exp 4", b_if.stall_cycles); end
    drdy = 1'b1; br = 1'b1;
    tick();
    tick();
    checks++; if (b_if.state !== 2'd2 || b_if.mem_fault !== 1'b1) begin
      errors++; $display("FAIL to_absorb got %0d/%b exp 2/1", b_if.state, b_if.mem_fault); end
    checks++; if (ctl_b() !== C_OFF) begin errors++; $display("FAIL to_ctl_hold got %b exp %b", ctl_b(), C_OFF); end
    checks++; if (b_if.stall_cycles !== 4'd4 || b_if.flush_events !== 4'd0) begin
      errors++; $display("FAIL to_cnt_hold got %0d/%0d exp 4/0", b_if.stall_cycles, b_if.flush_events); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    idle();
    #1;
    checks++; if (b_if.state !== 2'd0 || b_if.mem_fault !== 1'b0) begin
      errors++; $display("FAIL to_reset got %0d/%b exp 0/0", b_if.state, b_if.mem_fault); end
    checks++; if (b_if.stall_cycles !== 4'd0 || b_if.flush_events !== 4'd0) begin
      errors++; $display("FAIL to_reset_cnt got %0d/%0d exp 0/0", b_if.stall_cycles, b_if.flush_events); end
    checks++; if (ctl_b() !== C_RUN) begin errors++; $display("FAIL to_reset_ctl got %b exp %b", ctl_b(), C_RUN); end
  endtask

  task automatic test_saturation();
    logic [3:0] exp_b;
    do_reset();
    set_loaduse(5'd5);
    for (int i = 1; i <= 20; i++) begin
      tick();
      exp_b = (i >= 15) ? 4'd15 : 4'(i);
      checks++; if (b_if.stall_cycles !== exp_b) begin
        errors++; $display("FAIL sat_b[%0d] got %0d exp %0d", i, b_if.stall_cycles, exp_b); end
    end
    checks++; if (a_if.stall_cycles !== 32'd20) begin errors++; $display("FAIL sat_a got %0d exp 20", a_if.stall_cycles); end
    idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    idle();
    test_reset();
    test_load_use();
    test_branch_over_loaduse();
    test_mem_wait();
    test_branch_during_wait();
    test_spurious_wait();
    test_timeout();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
